// File: rtl/mul_result_accumulator.sv
// Sums TAP_NUM consecutive multiplier products per frame and emits the sum with a
// sticky overflow flag over valid/ready; a new frame may start while the old sum drains.
module mul_result_accumulator #(
    parameter int unsigned MUL_SIZE  = 32,
    parameter int unsigned PROD_SIZE = 2 * MUL_SIZE,
    parameter int unsigned ACC_SIZE  = 2 * MUL_SIZE,
    parameter int unsigned TAP_NUM   = 11,
    parameter int unsigned CNT_W     = $clog2(TAP_NUM + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PROD_SIZE-1:0] in_prod,
    input  logic                 in_prod_signed,
    input  logic                 in_valid,
    output logic                 out_ready,
    input  logic                 in_clear,
    output logic [ACC_SIZE-1:0]  out_sum,
    output logic                 out_overflow,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_valid,
    input  logic                 in_ready
);

    localparam int unsigned MSB = ACC_SIZE - 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic [ACC_SIZE-1:0] sum_q, sum_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;

    logic [ACC_SIZE-1:0] ext;
    logic [ACC_SIZE:0]   sum_wide;
    logic [ACC_SIZE-1:0] nxt;
    logic                carry_out;
    logic                carry_msb;
    logic                add_ovf;
    logic                accept;
    logic                send;
    logic                last;

    // Product extension and single-add overflow detection
    always_comb begin
        if (in_prod_signed) begin
            ext = ACC_SIZE'($signed(in_prod));
        end else begin
            ext = ACC_SIZE'(in_prod);
        end
        sum_wide  = {1'b0, acc_q} + {1'b0, ext};
        nxt       = sum_wide[MSB:0];
        carry_out = sum_wide[ACC_SIZE];
        carry_msb = acc_q[MSB] ^ ext[MSB] ^ nxt[MSB];
        add_ovf   = in_prod_signed ? (carry_msb ^ carry_out) : carry_out;
    end

    assign out_ready = !in_clear && ((state_q == ST_ACC) || in_ready);
    assign accept    = in_valid && out_ready;
    assign send      = valid_q && in_ready;
    assign last      = (cnt_q == CNT_W'(TAP_NUM - 1));

    // Next-state: clear dominates; a send and an accept can share a cycle
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        if (in_clear) begin
            state_d  = ST_ACC;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            valid_d  = 1'b0;
        end else begin
            if (send) begin
                valid_d = 1'b0;
                state_d = ST_ACC;
            end
            if (accept) begin
                if (last) begin
                    sum_d    = nxt;
                    ovf_d    = sticky_q | add_ovf;
                    valid_d  = 1'b1;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    state_d  = ST_HOLD;
                end else begin
                    acc_d    = nxt;
                    cnt_d    = cnt_q + CNT_W'(1);
                    sticky_d = sticky_q | add_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACC;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign out_sum      = sum_q;
    assign out_overflow = ovf_q;
    assign out_count    = cnt_q;
    assign out_valid    = valid_q;

endmodule

// File: tb/tb_mul_result_accumulator.sv
// Bench for mul_result_accumulator (TAP_NUM=4): table-driven frames plus handshake,
// clear and reset sequences, checked through a reference model and a result scoreboard.
module tb_mul_result_accumulator;

    localparam int TAP = 4;
    localparam int W   = 64;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_prod;
    logic          in_prod_signed;
    logic          in_valid;
    logic          out_ready;
    logic          in_clear;
    logic [W-1:0]  out_sum;
    logic          out_overflow;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          in_ready;

    mul_result_accumulator #(
        .MUL_SIZE (32),
        .TAP_NUM  (TAP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_prod        (in_prod),
        .in_prod_signed (in_prod_signed),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_clear       (in_clear),
        .out_sum        (out_sum),
        .out_overflow   (out_overflow),
        .out_count      (out_count),
        .out_valid      (out_valid),
        .in_ready       (in_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [3:0][W-1:0] p;
        logic [3:0]        sg;
        logic [W-1:0]      sum;
        logic              ovf;
    } vec_t;

    int     n_checks = 0;
    int     n_err    = 0;
    res_t   exp_q[$];
    res_t   got_q[$];
    vec_t   tbl[9];

    logic [W-1:0] m_acc;
    int           m_cnt;
    logic         m_sticky;
    logic         m_pending;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc     = '0;
        m_cnt     = 0;
        m_sticky  = 1'b0;
        m_pending = 1'b0;
        exp_q.delete();
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic [3:0] sg, input logic [W-1:0] sum,
                                input logic ovf);
        vec_t v;
        v.p[0] = a;
        v.p[1] = b;
        v.p[2] = c;
        v.p[3] = d;
        v.sg   = sg;
        v.sum  = sum;
        v.ovf  = ovf;
        return v;
    endfunction

    // One cycle: drive at negedge, check against the model, update model, wait a cycle
    task automatic step(input logic v, input logic [W-1:0] p, input logic s,
                        input logic rdy, input logic clr);
        logic         m_ready;
        logic         acc_ok;
        logic         snd;
        logic [W-1:0] r;
        logic [W:0]   wide;
        logic         o;
        res_t         e;
        in_valid       = v;
        in_prod        = p;
        in_prod_signed = s;
        in_ready       = rdy;
        in_clear       = clr;
        #1;
        m_ready = !clr && (!m_pending || rdy);
        chk("out_ready", W'(out_ready), W'(m_ready));
        chk("out_valid", W'(out_valid), W'(m_pending));
        chk("out_count", W'(out_count), W'(m_cnt));
        acc_ok = v && m_ready;
        snd    = m_pending && rdy;
        if (clr) begin
            model_reset();
        end else begin
            if (snd) begin
                got_q.push_back(res_t'{sum: out_sum, ovf: out_overflow});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL scoreboard: got send of 0x%h, want none", out_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", out_sum, e.sum);
                    chk("sb_overflow", W'(out_overflow), W'(e.ovf));
                end
                m_pending = 1'b0;
            end
            if (acc_ok) begin
                r = m_acc + p;
                if (s) begin
                    o = (m_acc[W-1] == p[W-1]) && (r[W-1] != m_acc[W-1]);
                end else begin
                    wide = {1'b0, m_acc} + {1'b0, p};
                    o    = wide[W];
                end
                if (m_cnt == TAP - 1) begin
                    exp_q.push_back(res_t'{sum: r, ovf: m_sticky | o});
                    m_pending = 1'b1;
                    m_acc     = '0;
                    m_cnt     = 0;
                    m_sticky  = 1'b0;
                end else begin
                    m_acc    = r;
                    m_cnt    = m_cnt + 1;
                    m_sticky = m_sticky | o;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_now();
        in_valid = 1'b0;
        in_clear = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_sum", out_sum, '0);
        chk("rst_out_overflow", W'(out_overflow), '0);
        chk("rst_out_count", W'(out_count), '0);
        chk("rst_out_ready", W'(out_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        got_q.delete();
    endtask

    task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic s, input logic rdy);
        step(1'b1, a, s, rdy, 1'b0);
        step(1'b1, b, s, rdy, 1'b0);
        step(1'b1, c, s, rdy, 1'b0);
        step(1'b1, d, s, rdy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    initial begin
        res_t g;
        logic [W-1:0] held;
        tbl[0] = mk(64'd1, 64'd2, 64'd3, 64'd4, 4'b0000, 64'd10, 1'b0);
        tbl[1] = mk(64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                    4'b1111, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        tbl[2] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                    4'b0000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        tbl[3] = mk(64'd1, 64'd1, 64'd1, 64'd1, 4'b0000, 64'd4, 1'b0);
        tbl[4] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                    4'b1111, 64'h8000_0000_0000_0000, 1'b1);
        tbl[5] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    4'b1111, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        tbl[6] = mk(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                    4'b1111, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        tbl[7] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd5, 64'd0, 4'b0000, 64'd5, 1'b1);
        tbl[8] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 4'b0001, 64'd0, 1'b1);

        rst_n          = 1'b0;
        in_prod        = '0;
        in_prod_signed = 1'b0;
        in_valid       = 1'b0;
        in_clear       = 1'b0;
        in_ready       = 1'b0;
        model_reset();
        #3;
        chk("init_out_valid", W'(out_valid), '0);
        chk("init_out_sum", out_sum, '0);
        chk("init_out_count", W'(out_count), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back table frames, downstream always ready
        got_q.delete();
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < TAP; j++) begin
                step(1'b1, tbl[i].p[j], tbl[i].sg[j], 1'b1, 1'b0);
            end
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (got_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL table_%0d: got no output, want sum 0x%h", i, tbl[i].sum);
            end else begin
                g = got_q.pop_front();
                chk($sformatf("table_%0d_sum", i), g.sum, tbl[i].sum);
                chk($sformatf("table_%0d_ovf", i), W'(g.ovf), W'(tbl[i].ovf));
            end
        end

        // Back-pressure: sum held for 5 cycles, then send and accept together
        frame(64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 1'b0);
        held = out_sum;
        chk("hold_sum_loaded", held, 64'd10);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 64'd9, 1'b0, 1'b0, 1'b0);
            chk("hold_sum_stable", out_sum, 64'd10);
        end
        step(1'b1, 64'd9, 1'b0, 1'b1, 1'b0);
        chk("overlap_count", W'(out_count), W'(1));
        step(1'b1, 64'd9, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd9, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd9, 1'b0, 1'b1, 1'b0);
        chk("overlap_sum", out_sum, 64'd36);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Clear mid-frame drops the partial sum and blocks the offered product
        step(1'b1, 64'd7, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd7, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd5, 1'b0, 1'b1, 1'b1);
        chk("clear_count", W'(out_count), '0);
        chk("clear_sum_kept", out_sum, 64'd36);
        frame(64'd1, 64'd1, 64'd1, 64'd1, 1'b0, 1'b1);
        chk("after_clear_sum", out_sum, 64'd4);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Clear while a sum is pending drops it
        frame(64'd2, 64'd2, 64'd2, 64'd2, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame and with a sum pending
        step(1'b1, 64'd1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'd2, 1'b0, 1'b1, 1'b0);
        chk("pre_reset_count", W'(out_count), W'(2));
        reset_now();
        frame(64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 1'b0);
        reset_now();
        frame(64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 1'b1);
        chk("post_reset_sum", out_sum, 64'd10);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        chk("scoreboard_empty", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
